// File: rtl/ntt_ctrl_if.sv
// Handshake and address bus between the NTT sequencer and its host / RAM / butterfly core.
// Carries scale_sel only when NTT_CTRL_SCALE_EN is defined.
interface ntt_ctrl_if;
    logic       start;
    logic       inv;
    logic       busy;
    logic       done;
    logic [2:0] layer;
    logic       rd_en;
    logic [7:0] rd_addr_1;
    logic [7:0] rd_addr_2;
    logic [6:0] tw_addr;
    logic [1:0] bf_mode;
    logic       wr_en;
    logic [7:0] wr_addr_1;
    logic [7:0] wr_addr_2;
`ifdef NTT_CTRL_SCALE_EN
    logic       scale_sel;
`endif

    modport master (
`ifdef NTT_CTRL_SCALE_EN
        input  scale_sel,
`endif
        output start, inv,
        input  busy, done, layer, rd_en, rd_addr_1, rd_addr_2, tw_addr, bf_mode,
               wr_en, wr_addr_1, wr_addr_2
    );

    modport slave (
`ifdef NTT_CTRL_SCALE_EN
        output scale_sel,
`endif
        input  start, inv,
        output busy, done, layer, rd_en, rd_addr_1, rd_addr_2, tw_addr, bf_mode,
               wr_en, wr_addr_1, wr_addr_2
    );
endinterface

// File: rtl/ntt_ctrl.sv
// Sequencer for one 256-coefficient Kyber NTT/INTT pass with delay-matched write-back.
// Optional INTT scaling pass enabled by defining NTT_CTRL_SCALE_EN.
module ntt_ctrl #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 5
) (
    input  logic       clk,
    input  logic       rst,
    ntt_ctrl_if.slave  bus
);
    localparam int unsigned D      = RD_LAT + BF_LAT;
    localparam logic [7:0]  D_LAST = 8'(D - 1);
`ifdef NTT_CTRL_SCALE_EN
    localparam logic [7:0]  SD_LAST = 8'(D - 2);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
`ifdef NTT_CTRL_SCALE_EN
        S_SCALE,
        S_SDRAIN,
`endif
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] b_q, b_d;
    logic [7:0] dc_q, dc_d;
    logic [2:0] layer_q, layer_d;
    logic       inv_q, inv_d;

    logic       rd_en_c;
    logic [7:0] rd1_c, rd2_c;
    logic [6:0] tw_c;
    logic [1:0] mode_c;
    logic       scale_c;
    logic       busy_c, done_c;

    logic [7:0] len8, mask8, j8;
    logic [6:0] g7, k7;

    logic       wen_q [D];
    logic       wen_d [D];
    logic [7:0] wa1_q [D];
    logic [7:0] wa1_d [D];
    logic [7:0] wa2_q [D];
    logic [7:0] wa2_d [D];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            dc_q    <= '0;
            layer_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            dc_q    <= dc_d;
            layer_q <= layer_d;
            inv_q   <= inv_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        dc_d    = dc_q;
        layer_d = layer_q;
        inv_d   = inv_q;
        unique case (state_q)
            S_IDLE: begin
                layer_d = '0;
                if (bus.start) begin
                    state_d = S_RUN;
                    inv_d   = bus.inv;
                    b_d     = '0;
                end
            end
            S_RUN: begin
                b_d = b_q + 7'd1;
                if (b_q == 7'd127) begin
                    state_d = S_DRAIN;
                    dc_d    = '0;
                end
            end
            S_DRAIN: begin
                dc_d = dc_q + 8'd1;
                if (dc_q == D_LAST) begin
                    dc_d = '0;
                    if (layer_q != 3'd6) begin
                        state_d = S_RUN;
                        layer_d = layer_q + 3'd1;
                        b_d     = '0;
                    end
`ifdef NTT_CTRL_SCALE_EN
                    else if (inv_q) begin
                        state_d = S_SCALE;
                        b_d     = '0;
                    end
`endif
                    else begin
                        state_d = S_DONE;
                    end
                end
            end
`ifdef NTT_CTRL_SCALE_EN
            S_SCALE: begin
                b_d = b_q + 7'd1;
                if (b_q == 7'd127) begin
                    state_d = S_SDRAIN;
                    dc_d    = '0;
                end
            end
            S_SDRAIN: begin
                dc_d = dc_q + 8'd1;
                if (dc_q == SD_LAST) begin
                    dc_d    = '0;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                layer_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pair/twiddle addressing: groups are power-of-two sized, so g*2*len and b%len become shift/mask
    always_comb begin
        if (!inv_q) begin
            len8  = 8'd128 >> layer_q;
            g7    = b_q >> (3'd7 - layer_q);
            mask8 = len8 - 8'd1;
            j8    = ({1'b0, g7} << (4'd8 - {1'b0, layer_q})) | ({1'b0, b_q} & mask8);
            k7    = (7'd1 << layer_q) + g7;
        end else begin
            len8  = 8'd2 << layer_q;
            g7    = b_q >> ({1'b0, layer_q} + 4'd1);
            mask8 = len8 - 8'd1;
            j8    = ({1'b0, g7} << ({1'b0, layer_q} + 4'd2)) | ({1'b0, b_q} & mask8);
            k7    = (7'd127 >> layer_q) - g7;
        end
    end

    // Output logic
    always_comb begin
        rd_en_c = 1'b0;
        rd1_c   = '0;
        rd2_c   = '0;
        tw_c    = '0;
        mode_c  = '0;
        scale_c = 1'b0;
        busy_c  = (state_q != S_IDLE);
        done_c  = (state_q == S_DONE);
        unique case (state_q)
            S_RUN: begin
                rd_en_c = 1'b1;
                rd1_c   = j8;
                rd2_c   = j8 + len8;
                tw_c    = k7;
                mode_c  = {1'b0, inv_q};
            end
            S_DRAIN: mode_c = {1'b0, inv_q};
`ifdef NTT_CTRL_SCALE_EN
            S_SCALE: begin
                rd_en_c = 1'b1;
                rd1_c   = {b_q, 1'b0};
                rd2_c   = {b_q, 1'b1};
                mode_c  = 2'd2;
                scale_c = 1'b1;
            end
            S_SDRAIN: begin
                mode_c  = 2'd2;
                scale_c = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Write-back delay line shifts in every state so drained writes still land
    always_comb begin
        wen_d[0] = rd_en_c;
        wa1_d[0] = rd1_c;
        wa2_d[0] = rd2_c;
        for (int unsigned i = 1; i < D; i++) begin
            wen_d[i] = wen_q[i-1];
            wa1_d[i] = wa1_q[i-1];
            wa2_d[i] = wa2_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < D; i++) begin
                wen_q[i] <= 1'b0;
                wa1_q[i] <= '0;
                wa2_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < D; i++) begin
                wen_q[i] <= wen_d[i];
                wa1_q[i] <= wa1_d[i];
                wa2_q[i] <= wa2_d[i];
            end
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.layer     = layer_q;
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr_1 = rd1_c;
    assign bus.rd_addr_2 = rd2_c;
    assign bus.tw_addr   = tw_c;
    assign bus.bf_mode   = mode_c;
    assign bus.wr_en     = wen_q[D-1];
    assign bus.wr_addr_1 = wa1_q[D-1];
    assign bus.wr_addr_2 = wa2_q[D-1];
`ifdef NTT_CTRL_SCALE_EN
    assign bus.scale_sel = scale_c;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed testbench for ntt_ctrl: cycle-indexed expectations for full NTT/INTT passes,
// write-back delay, ignored starts and asynchronous abort.
module tb_ntt_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass   = 0;
    int   n_checks = 0;

`ifdef NTT_CTRL_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    ntt_ctrl_if bus ();

    ntt_ctrl #(.RD_LAT(1), .BF_LAT(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // {rd1, rd2, tw} for butterfly b of layer l
    function automatic logic [22:0] ref_addr(input logic inv, input int l, input int b);
        int len, g, j, k;
        if (!inv) begin
            len = 128 >> l;
            g   = b / len;
            k   = (1 << l) + g;
        end else begin
            len = 2 << l;
            g   = b / len;
            k   = (128 >> l) - 1 - g;
        end
        j = g * 2 * len + b % len;
        return {8'(j), 8'(j + len), 7'(k)};
    endfunction

    // {rd_en, rd1, rd2, tw, bf_mode, layer, busy, done, scale_sel}
    function automatic logic [31:0] ref_vec(input logic inv, input int c, input int dc);
        int r, l;
        logic [22:0] a;
        if (c < 1 || c > dc) return '0;
        if (c == dc) return {1'b0, 23'd0, 2'd0, 3'd6, 1'b1, 1'b1, 1'b0};
        if (c <= 938) begin
            l = (c - 1) / 134;
            r = (c - 1) % 134;
            if (r < 128) begin
                a = ref_addr(inv, l, r);
                return {1'b1, a, 1'b0, inv, 3'(l), 1'b1, 1'b0, 1'b0};
            end
            return {1'b0, 23'd0, 1'b0, inv, 3'(l), 1'b1, 1'b0, 1'b0};
        end
        r = c - 939;
        if (r < 128)
            return {1'b1, 8'(2 * r), 8'(2 * r + 1), 7'd0, 2'd2, 3'd6, 1'b1, 1'b0, 1'b1};
        return {1'b0, 23'd0, 2'd2, 3'd6, 1'b1, 1'b0, 1'b1};
    endfunction

    function automatic logic [31:0] obs_vec();
        logic sc;
`ifdef NTT_CTRL_SCALE_EN
        sc = bus.scale_sel;
`else
        sc = 1'b0;
`endif
        return {bus.rd_en, bus.rd_addr_1, bus.rd_addr_2, bus.tw_addr, bus.bf_mode,
                bus.layer, bus.busy, bus.done, sc};
    endfunction

    function automatic logic [48:0] obs_all();
        return {obs_vec(), bus.wr_en, bus.wr_addr_1, bus.wr_addr_2};
    endfunction

    // Hand-computed address spots: {inv, cycle, rd1, rd2, tw}
    typedef struct { logic inv; int c; logic [7:0] a1; logic [7:0] a2; logic [6:0] tw; } spot_t;
    spot_t spots [9] = '{
        '{1'b0,   1,   8'd0, 8'd128, 7'd1},
        '{1'b0,   2,   8'd1, 8'd129, 7'd1},
        '{1'b0, 135,   8'd0,  8'd64, 7'd2},
        '{1'b0, 199,   8'd128, 8'd192, 7'd3},
        '{1'b0, 932, 8'd253, 8'd255, 7'd127},
        '{1'b1,   1,   8'd0,   8'd2, 7'd127},
        '{1'b1,   2,   8'd1,   8'd3, 7'd127},
        '{1'b1,   3,   8'd4,   8'd6, 7'd126},
        '{1'b1, 805,   8'd0, 8'd128, 7'd1}
    };

    task automatic run_pass(input logic inv_i, input bit pulses, input int abort_c);
        int dc, wr_cnt, done_cnt;
        logic [31:0] e;
        logic [16:0] hist [0:1100];
        logic [16:0] wexp;
        dc = (inv_i && SCALE) ? 1072 : 939;
        wr_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i <= 1100; i++) hist[i] = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.inv   = inv_i;
        for (int c = 1; c <= dc + 8; c++) begin
            @(negedge clk);
            bus.inv = ~inv_i;
            e = ref_vec(inv_i, c, dc);
            hist[c] = {e[31], e[30:23], e[22:15]};
            check($sformatf("ctl inv=%0d c=%0d", inv_i, c), 64'(obs_vec()), 64'(e));
            wexp = (c >= 6) ? hist[c-6] : 17'd0;
            check($sformatf("wr inv=%0d c=%0d", inv_i, c),
                  64'({bus.wr_en, bus.wr_addr_1, bus.wr_addr_2}), 64'(wexp));
            foreach (spots[s])
                if (spots[s].inv == inv_i && spots[s].c == c)
                    check($sformatf("spot inv=%0d c=%0d", inv_i, c),
                          64'({bus.rd_en, bus.rd_addr_1, bus.rd_addr_2, bus.tw_addr}),
                          64'({1'b1, spots[s].a1, spots[s].a2, spots[s].tw}));
            if (bus.wr_en) wr_cnt++;
            if (bus.done) done_cnt++;
            bus.start = pulses && (c == 10 || c == 500 || c == dc);
            if (c == abort_c) begin
                rst = 1'b1;
                #1;
                check("abort_async", 64'(obs_all()), 64'd0);
                @(negedge clk);
                check("abort_next", 64'(obs_all()), 64'd0);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("abort_idle", 64'(obs_all()), 64'd0);
                return;
            end
        end
        check($sformatf("wr_count inv=%0d", inv_i), 64'(wr_cnt), (inv_i && SCALE) ? 64'd1024 : 64'd896);
        check($sformatf("done_pulses inv=%0d", inv_i), 64'(done_cnt), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.inv   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_held", 64'(obs_all()), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle %0d", i), 64'(obs_all()), 64'd0);
        end
        run_pass(1'b0, 1'b0, -1);
        run_pass(1'b1, 1'b0, -1);
        run_pass(1'b0, 1'b1, -1);
        run_pass(1'b1, 1'b0, 300);
        run_pass(1'b0, 1'b0, -1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
